// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the BCD down-timer: FSM state encoding,
// BCD digit width/limit and the per-digit load clamp.
package bcd_down_timer_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Non-decimal nibbles (A..F) are treated as the largest legal digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One BCD digit of the down-count ripple chain; 0 with a borrow wraps to 9
// and passes the borrow to the next digit. Purely combinational.
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_out,
  output logic             borrow_out
);

  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-timer with run/pause control, one-cycle done
// pulse and freezable display output. Optional macro: BCD_TIMER_AUTO_RELOAD_EN.
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  freeze,
  output logic [4*DIGITS-1:0]   data,
  output logic                  running,
  output logic                  done
);

  localparam int CW = BCD_W * DIGITS;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   data_q;
  logic            running_q;
  logic            done_q, done_d;
  logic [CW-1:0]   count_dec;
  logic [CW-1:0]   load_clean;
  logic [DIGITS:0] borrow;
  logic            cnt_zero;
  logic            dec_zero;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [CW-1:0]   reload_q;
`endif

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .digit_in  (count_q[g*BCD_W +: BCD_W]),
      .borrow_in (borrow[g]),
      .digit_out (count_dec[g*BCD_W +: BCD_W]),
      .borrow_out(borrow[g+1])
    );
    assign load_clean[g*BCD_W +: BCD_W] = bcd_clamp(load_value[g*BCD_W +: BCD_W]);
  end

  // A borrow escaping the top digit means every digit was already zero.
  assign cnt_zero = borrow[DIGITS];
  assign dec_zero = (count_dec == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_clean;
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start && (state_q != RUN)) begin
      if (!cnt_zero) state_d = RUN;
    end else if ((state_q == RUN) && clken && !cnt_zero) begin
      count_d = count_dec;
      if (dec_zero) begin
        done_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        if (reload_q != '0) count_d = reload_q;
        else                state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      data_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == RUN);
      done_q    <= done_d;
      // Display shows the pre-update count, so it trails the count by one clock.
      if (!freeze) data_q <= count_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      if (load) reload_q <= load_clean;
`endif
    end
  end

  assign data    = data_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: an integer-valued behavioural model is
// checked against the outputs every cycle, plus hand-computed literal checks.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        reset, clken, load, start, stop, freeze;
  logic [15:0] load_value;
  logic [15:0] data;
  logic        running, done;

  int total = 0;
  int bad   = 0;

  bcd_down_timer #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .clken(clken), .load(load),
    .load_value(load_value), .start(start), .stop(stop), .freeze(freeze),
    .data(data), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  // Model state: plain decimal integers, state as 0=idle 1=run 2=pause.
  int m_cnt = 0, m_st = 0, m_data = 0, m_rel = 0;
  bit m_done = 0, m_run = 0;

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int x = n;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    int pre;
    pre = m_cnt;
    if (reset) begin
      m_cnt = 0; m_st = 0; m_data = 0; m_rel = 0; m_done = 0; m_run = 0;
    end else begin
      m_done = 0;
      if (load) begin
        m_cnt = bcd2int(load_value);
        m_rel = m_cnt;
        m_st  = 0;
      end else if (stop) begin
        if (m_st == 1) m_st = 2;
      end else if (start && m_st != 1) begin
        if (m_cnt != 0) m_st = 1;
      end else if (m_st == 1 && clken && m_cnt != 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
          if (m_rel != 0) m_cnt = m_rel;
          else            m_st = 0;
`else
          m_st = 0;
`endif
        end
      end
      if (!freeze) m_data = pre;
      m_run = (m_st == 1);
    end
  end

  always @(negedge clk) begin
    total++;
    if (data !== int2bcd(m_data)) begin
      bad++;
      $display("FAIL model_data: got %h want %h at %0t", data, int2bcd(m_data), $time);
    end
    total++;
    if (running !== m_run) begin
      bad++;
      $display("FAIL model_running: got %b want %b at %0t", running, m_run, $time);
    end
    total++;
    if (done !== m_done) begin
      bad++;
      $display("FAIL model_done: got %b want %b at %0t", done, m_done, $time);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clken = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    freeze = 1'b0; load_value = '0;

    // Reset, then start with a zero count is ignored.
    step(2);
    check("rst_data", data, 16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    reset = 1'b0;
    do_start();
    step(2);
    check("start_zero_running", {15'd0, running}, 16'd0);

    // Count 12 down to zero.
    do_load(16'h0012);
    do_start();
    clken = 1'b1;
    step(11);
    check("cnt12_pre_done", {15'd0, done}, 16'd0);
    check("cnt12_pre_running", {15'd0, running}, 16'd1);
    step(1);
    check("cnt12_done", {15'd0, done}, 16'd1);
    check("cnt12_running_fall", {15'd0, running}, 16'd0);
    check("cnt12_data_lag", data, 16'h0001);
    step(1);
    check("cnt12_done_once", {15'd0, done}, 16'd0);
    check("cnt12_data_zero", data, 16'h0000);
    clken = 1'b0;

    // Borrow across three digits.
    do_load(16'h1000);
    do_start();
    clken = 1'b1; step(1); clken = 1'b0;
    step(1);
    check("borrow_0999", data, 16'h0999);

    // Pause with clken held, resume, start+stop together.
    do_load(16'h0005);
    do_start();
    clken = 1'b1; step(2);
    stop = 1'b1; step(5);
    check("pause_running", {15'd0, running}, 16'd0);
    stop = 1'b0; clken = 1'b0; step(1);
    check("pause_hold", data, 16'h0003);
    do_start();
    clken = 1'b1; step(1); clken = 1'b0; step(1);
    check("resume_0002", data, 16'h0002);
    check("resume_running", {15'd0, running}, 16'd1);
    start = 1'b1; stop = 1'b1; step(1);
    start = 1'b0; stop = 1'b0;
    check("start_stop_pause", {15'd0, running}, 16'd0);

    // Freeze holds the display while counting continues.
    do_load(16'h0005);
    do_start();
    freeze = 1'b1; clken = 1'b1; step(2);
    check("freeze_hold", data, 16'h0005);
    freeze = 1'b0; clken = 1'b0; step(1);
    check("freeze_release", data, 16'h0003);

    // Load sanitising.
    do_load(16'h0C3A);
    step(1);
    check("sanitise_0939", data, 16'h0939);

    // Zero handling with a preset of 2.
    do_load(16'h0002);
    do_start();
    clken = 1'b1; step(2);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    check("reload_done", {15'd0, done}, 16'd1);
    check("reload_running", {15'd0, running}, 16'd1);
    step(4);
    check("reload_still_running", {15'd0, running}, 16'd1);
`else
    check("two_done", {15'd0, done}, 16'd1);
    check("two_idle", {15'd0, running}, 16'd0);
    step(2);
`endif
    clken = 1'b0;

    // Load mid-run with clken: load wins, then reset mid-run without done.
    do_load(16'h0050);
    do_start();
    clken = 1'b1; load = 1'b1; load_value = 16'h0030; step(1);
    load = 1'b0; clken = 1'b0; step(1);
    check("load_wins", data, 16'h0030);
    do_start();
    clken = 1'b1; step(1);
    reset = 1'b1; step(1);
    reset = 1'b0; clken = 1'b0;
    check("reset_mid_run", {14'd0, running, done}, 16'd0);
    step(1);
    check("reset_mid_data", data, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
Multi-digit, loadable BCD down-counter with run/pause control and a one-cycle done pulse.
- Counts in the opposite direction to the BCD up-counter chain.
- Decrements one count per clken tick (e.g. 1 Hz enable from the prescaler) until zero.
- Feeds the same 7-segment display path and uses the same output freeze semantics.

Parameters:
DIGITS, 4, number of BCD digits; count width = 4*DIGITS.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous reset, active-high
clken  in  1  count tick; one decrement per clk with clken=1 in RUN
load  in  1  load load_value into count, force IDLE
load_value  in  4*DIGITS  BCD preset; digit 0 = bits [3:0]
start  in  1  IDLE/PAUSE -> RUN
stop  in  1  RUN -> PAUSE
freeze  in  1  hold data output; internal count unaffected
data  out  4*DIGITS  registered BCD count
running  out  1  1 while state == RUN
done  out  1  1-clk pulse when count reaches zero

Behaviour:
- Clocking and reset: single clock domain (clk); reset is synchronous and active-high.
- Reset values: count = 0, data = 0, state = IDLE, running = 0, done = 0.
- Priority each edge: reset > load > stop > start > clken decrement.
- FSM states:
  - IDLE: start with count != 0 -> RUN. start with count == 0 is ignored; done stays 0.
  - RUN: stop -> PAUSE. clken=1 and count != 0 -> count decrements. If the decremented value is 0: done=1 on the same edge, state -> IDLE.
  - PAUSE: start -> RUN. clken is ignored.
  - load in any state -> IDLE, count = load_value.
  - start and stop asserted together: stop wins. From IDLE this means the state stays IDLE.
- Load sanitising: any load_value digit > 9 is loaded as 9, per digit.
- Decrement arithmetic:
  - Ripple borrow from digit 0 upward. A digit at 0 with borrow-in becomes 9 and borrows out.
  - Count never wraps below 0, because the zero check prevents decrement at 0.
- running is a registered copy of (state == RUN), so it updates on the same edge as the state.
- done is high for exactly 1 clk and is not affected by freeze.
- data:
  - When freeze=0 at an edge, data <= count value before that edge's update. data therefore lags count by 1 clk.
  - When freeze=1, data holds.
  - On freeze release, data picks up the current count at the next edge.
- Reset mid-RUN: returns to IDLE and count = 0 in that cycle. No done pulse.
- Load mid-RUN with clken=1: load wins and no decrement occurs.

Optional Feature:
Macro: BCD_TIMER_AUTO_RELOAD_EN
- Defined:
  - An internal reload register captures the sanitised load_value on load and is cleared by reset.
  - When count reaches 0 in RUN: done pulses, count <= reload register, state stays RUN.
  - If the reload register is 0, behaviour falls back to going IDLE.
- Not defined: no reload register; the timer returns to IDLE at zero.

Decomposition:
- Shared package:
  - State enum {IDLE, RUN, PAUSE}.
  - Constant BCD_MAX = 4'd9.
  - Constant BCD_W = 4.
- Sub-module bcd_down_digit (one per digit, generate loop):
  - Inputs: digit_in, borrow_in.
  - Outputs: digit_out, borrow_out.
  - Purely combinational.
  - Digit 0 takes borrow_in = 1 (decrement request).

Test Plan:
1. Assert reset 2 clk -> data=0000, running=0, done=0. start with count 0 -> still IDLE, done never 1.
2. load 0x0012, start, clken every clk -> count 0011,0010,0009,...,0000. done=1 for exactly 1 clk on the edge count becomes 0000. running falls on the same edge. data shows 0000 one clk later.
3. load 0x1000, start, single clken pulse -> count 0999 (borrow across three digits).
4. load 0x0005, start, 2 clken, stop with clken held high 5 clk -> count stays 0003. start -> resumes 0002 on next clken. start+stop together in RUN -> PAUSE.
5. Counting from 0x0005, freeze=1 for 2 ticks -> data holds 0005 while count goes to 0003. freeze=0 -> data=0003 on the next edge.
6. load_value 0x0C3A -> count 0939. With BCD_TIMER_AUTO_RELOAD_EN, load 0x0002, run -> done pulses every 2 ticks, count cycles 0001,0002,0001, running stays 1.
